// File: rtl/rrp_stream_arbiter.sv
// rrp_stream_arbiter
// Round-robin arbiter with per-channel hold. It merges WIDTH FIFO-style word
// streams into one output stream and pops at most one word per cycle.
// Selection, data and grant paths are combinational. Only the arbitration
// state (last served channel, hold lock) is registered.
//
// Ports
//   CLK         clock, all state updates on the rising edge
//   RST         synchronous active-high reset
//   WRITE_REQ   per-channel word available (= !FIFO_EMPTY)
//   HOLD_REQ    per-channel request to keep ownership after its transfer
//   DATA_IN     channel i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   READ_GRANT  pop strobe to the selected channel (one-hot or zero)
//   READY_OUT   downstream can accept a word this cycle
//   WRITE_OUT   DATA_OUT valid
//   DATA_OUT    selected channel word
module rrp_stream_arbiter #(
  parameter int WIDTH      = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [WIDTH-1:0]            WRITE_REQ,
  input  logic [WIDTH-1:0]            HOLD_REQ,
  input  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0]            READ_GRANT,
  input  logic                        READY_OUT,
  output logic                        WRITE_OUT,
  output logic [DATA_WIDTH-1:0]       DATA_OUT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]         cur;
  logic                  locked;
  logic [CW-1:0]         sel;
  logic                  transfer;
  logic [DATA_WIDTH-1:0] words [WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_words
    assign words[i] = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just after the last served channel and wraps around, so
  // cur itself is examined last. With no request, sel stays on cur.
  always_comb begin
    logic          found;
    logic [CW-1:0] cand;
    sel   = cur;
    found = 1'b0;
    cand  = '0;
    if (!(locked && HOLD_REQ[cur])) begin
      for (int unsigned k = 1; k <= WIDTH; k++) begin
        cand = CW'((32'(cur) + k) % WIDTH);
        if (!found && WRITE_REQ[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign WRITE_OUT = !RST && WRITE_REQ[sel];
  assign DATA_OUT  = RST ? '0 : words[sel];
  assign transfer  = WRITE_OUT && READY_OUT;

  always_comb begin
    READ_GRANT = '0;
    if (transfer) READ_GRANT[sel] = 1'b1;
  end

  // Without a transfer the lock survives only while the owner keeps holding.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur    <= CW'(WIDTH - 1);
      locked <= 1'b0;
    end else if (transfer) begin
      cur    <= sel;
      locked <= HOLD_REQ[sel];
    end else if (!HOLD_REQ[cur]) begin
      locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rrp_stream_arbiter.sv
// Directed bench for rrp_stream_arbiter (WIDTH=2, DATA_WIDTH=32): a vector
// table applied one row per cycle, plus a rotation sequence with changing data.
module tb_rrp_stream_arbiter;

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  write_req;
  logic [1:0]  hold_req;
  logic [63:0] data_in;
  logic [1:0]  read_grant;
  logic        ready_out;
  logic        write_out;
  logic [31:0] data_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rrp_stream_arbiter #(.WIDTH(2), .DATA_WIDTH(32)) dut (
    .CLK        (clk),
    .RST        (rst),
    .WRITE_REQ  (write_req),
    .HOLD_REQ   (hold_req),
    .DATA_IN    (data_in),
    .READ_GRANT (read_grant),
    .READY_OUT  (ready_out),
    .WRITE_OUT  (write_out),
    .DATA_OUT   (data_out)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  wr;
    logic [1:0]  hold;
    logic        rdy;
    logic [1:0]  gnt;
    logic        wo;
    logic        dchk;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] wr, input logic [1:0] h,
                     input logic rdy, input logic [1:0] g, input logic wo,
                     input logic dchk, input logic [31:0] d);
    vec_t v;
    v.rst = r; v.wr = wr; v.hold = h; v.rdy = rdy;
    v.gnt = g; v.wo = wo; v.dchk = dchk; v.data = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic [1:0] g,
                               input logic wo, input logic dchk,
                               input logic [31:0] d);
    check("read_grant", idx, 32'(read_grant), 32'(g));
    check("write_out", idx, 32'(write_out), 32'(wo));
    if (dchk) check("data_out", idx, data_out, d);
  endtask

  initial begin
    logic [31:0] r0, r1;
    logic        expect_ch1;

    rst = 1'b1; write_req = '0; hold_req = '0; ready_out = 1'b0;
    data_in = {D1, D0};

    // rst wr hold rdy | gnt wo dchk data
    // alternation after reset
    add(1, 2'b11, 2'b00, 1, 2'b00, 0, 1, 32'h0);
    add(0, 2'b11, 2'b00, 1, 2'b01, 1, 1, D0);
    add(0, 2'b11, 2'b00, 1, 2'b10, 1, 1, D1);
    add(0, 2'b11, 2'b00, 1, 2'b01, 1, 1, D0);
    add(0, 2'b11, 2'b00, 1, 2'b10, 1, 1, D1);
    // single requester ch1, then idle
    add(0, 2'b10, 2'b00, 1, 2'b10, 1, 1, D1);
    add(0, 2'b10, 2'b00, 1, 2'b10, 1, 1, D1);
    add(0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 32'h0);
    // READY_OUT low for 5 cycles: no grant, state frozen
    add(1, 2'b11, 2'b00, 1, 2'b00, 0, 1, 32'h0);
    for (int i = 0; i < 5; i++) add(0, 2'b11, 2'b00, 0, 2'b00, 1, 1, D0);
    add(0, 2'b11, 2'b00, 1, 2'b01, 1, 1, D0);
    add(0, 2'b11, 2'b00, 1, 2'b10, 1, 1, D1);
    // hold on ch0
    add(1, 2'b11, 2'b01, 1, 2'b00, 0, 1, 32'h0);
    add(0, 2'b11, 2'b01, 1, 2'b01, 1, 1, D0);
    add(0, 2'b11, 2'b01, 1, 2'b01, 1, 1, D0);
    add(0, 2'b11, 2'b01, 1, 2'b01, 1, 1, D0);
    add(0, 2'b11, 2'b00, 1, 2'b10, 1, 1, D1);
    add(0, 2'b11, 2'b00, 1, 2'b01, 1, 1, D0);
    // held owner runs dry: stall until hold drops
    add(0, 2'b01, 2'b01, 1, 2'b01, 1, 1, D0);
    add(0, 2'b10, 2'b01, 1, 2'b00, 0, 0, 32'h0);
    add(0, 2'b10, 2'b01, 1, 2'b00, 0, 0, 32'h0);
    add(0, 2'b10, 2'b00, 1, 2'b10, 1, 1, D1);
    // reset mid-stream
    add(0, 2'b11, 2'b00, 1, 2'b01, 1, 1, D0);
    add(1, 2'b11, 2'b00, 1, 2'b00, 0, 1, 32'h0);
    add(0, 2'b11, 2'b00, 1, 2'b01, 1, 1, D0);
    add(0, 2'b11, 2'b00, 1, 2'b10, 1, 1, D1);
    // lock cleared by hold drop without a transfer
    add(0, 2'b01, 2'b01, 1, 2'b01, 1, 1, D0);
    add(0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 32'h0);
    add(0, 2'b11, 2'b01, 1, 2'b10, 1, 1, D1);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; write_req = vecs[i].wr;
      hold_req = vecs[i].hold; ready_out = vecs[i].rdy;
      #2;
      check_outputs(i, vecs[i].gnt, vecs[i].wo, vecs[i].dchk, vecs[i].data);
    end

    // Continuous rotation with fresh data every cycle; DATA_OUT must follow.
    @(negedge clk);
    rst = 1'b1; write_req = 2'b11; hold_req = 2'b00; ready_out = 1'b1;
    #2;
    check_outputs(100, 2'b00, 1'b0, 1'b1, 32'h0);
    expect_ch1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = 1'b0;
      r0 = $urandom; r1 = $urandom;
      data_in = {r1, r0};
      #2;
      check_outputs(101 + i, expect_ch1 ? 2'b10 : 2'b01, 1'b1, 1'b1,
                    expect_ch1 ? r1 : r0);
      expect_ch1 = !expect_ch1;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
